// File: rtl/noc_flit_sink.sv
// Receiving endpoint for one router output port: buffers flits, drains and checks them.
// Optional pseudo-random drain throttle enabled by defining NOC_FLIT_SINK_THROTTLE_EN.
module noc_flit_sink #(
    parameter int         DEPTH    = 8,
    parameter int         AW       = 3,
    parameter logic [3:0] LOCAL_TO = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_in,
    input  logic [15:0] data_in,
    input  logic        drain_en,
    output logic        full,
    output logic        almost_full,
    output logic        flit_valid_out,
    output logic [15:0] flit_out,
    output logic [1:0]  last_src,
    output logic [15:0] rx_count,
    output logic [7:0]  seq_err_count,
    output logic        dest_err,
    output logic        valid_err,
    output logic        overflow_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int          AF_INT   = DEPTH - 1;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] AF_LVL   = AF_INT[AW:0];
    localparam logic [AW:0] ONE_LVL  = {{AW{1'b0}}, 1'b1};

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [8:0]    exp_seq_q [4];
    logic          flit_valid_q;
    logic [15:0]   flit_q;
    logic [1:0]    last_src_q;
    logic [15:0]   rx_count_q;
    logic [7:0]    seq_err_q;
    logic          dest_err_q;
    logic          valid_err_q;
    logic          overflow_err_q;

    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          last_pop_s;
    logic          thr_ok_s;
    logic [15:0]   head_s;
    logic [8:0]    head_seq_s;
    logic [1:0]    head_src_s;

`ifdef NOC_FLIT_SINK_THROTTLE_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign thr_ok_s = lfsr_q[0];
`else
    assign thr_ok_s = 1'b1;
`endif

    // Backpressure comes only from registered occupancy, so a pop never frees a slot for the same-cycle write.
    assign empty_s     = (cnt_q == {(AW+1){1'b0}});
    assign full        = (cnt_q == FULL_LVL);
    assign almost_full = (cnt_q >= AF_LVL);

    assign push_s     = write_in & data_in[0] & ~full;
    assign pop_s      = ~empty_s & drain_en & thr_ok_s & (state_q != ST_HOLD);
    assign last_pop_s = pop_s & ~push_s & (cnt_q == ONE_LVL);

    assign head_s     = mem_q[rd_ptr_q];
    assign head_seq_s = head_s[15:7];
    assign head_src_s = head_s[6:5];

    // Occupancy next state
    always_comb begin
        cnt_d = cnt_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Drain FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s && !last_pop_s) state_d = ST_RUN;
                else                         state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!drain_en)       state_d = ST_HOLD;
                else if (last_pop_s) state_d = ST_IDLE;
                else                 state_d = ST_RUN;
            end
            ST_HOLD: begin
                if (drain_en) state_d = ST_RUN;
                else          state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage, pointers, occupancy and FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {(AW+1){1'b0}};
            state_q  <= ST_IDLE;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Drained-flit outputs and per-source sequence checking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_valid_q <= 1'b0;
            flit_q       <= 16'h0000;
            last_src_q   <= 2'b00;
            rx_count_q   <= 16'h0000;
            seq_err_q    <= 8'h00;
            dest_err_q   <= 1'b0;
            for (int s = 0; s < 4; s++) begin
                exp_seq_q[s] <= 9'd0;
            end
        end else begin
            flit_valid_q <= pop_s;
            if (pop_s) begin
                flit_q     <= head_s;
                last_src_q <= head_src_s;
                rx_count_q <= rx_count_q + 16'd1;
                if (head_s[4:1] != LOCAL_TO) begin
                    dest_err_q <= 1'b1;
                end
                // A mismatch resyncs to the received sequence so one gap costs one error.
                if ((head_seq_s != exp_seq_q[head_src_s]) && (seq_err_q != 8'hFF)) begin
                    seq_err_q <= seq_err_q + 8'd1;
                end
                exp_seq_q[head_src_s] <= head_seq_s + 9'd1;
            end
        end
    end

    // Sticky ingress error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_err_q    <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            if (write_in && full) begin
                overflow_err_q <= 1'b1;
            end
            if (write_in && !data_in[0]) begin
                valid_err_q <= 1'b1;
            end
        end
    end

    assign flit_valid_out = flit_valid_q;
    assign flit_out       = flit_q;
    assign last_src       = last_src_q;
    assign rx_count       = rx_count_q;
    assign seq_err_count  = seq_err_q;
    assign dest_err       = dest_err_q;
    assign valid_err      = valid_err_q;
    assign overflow_err   = overflow_err_q;

endmodule

// File: tb/tb_noc_flit_sink.sv
// Directed self-checking bench for noc_flit_sink (default build, LOCAL_TO = 4'b1011).
module tb_noc_flit_sink;

    logic        clk;
    logic        reset;
    logic        write_in;
    logic [15:0] data_in;
    logic        drain_en;
    logic        full;
    logic        almost_full;
    logic        flit_valid_out;
    logic [15:0] flit_out;
    logic [1:0]  last_src;
    logic [15:0] rx_count;
    logic [7:0]  seq_err_count;
    logic        dest_err;
    logic        valid_err;
    logic        overflow_err;

    int checks   = 0;
    int failures = 0;
    logic full_seen;

    noc_flit_sink #(
        .DEPTH(8),
        .AW(3),
        .LOCAL_TO(4'b1011)
    ) dut (
        .clk(clk),
        .reset(reset),
        .write_in(write_in),
        .data_in(data_in),
        .drain_en(drain_en),
        .full(full),
        .almost_full(almost_full),
        .flit_valid_out(flit_valid_out),
        .flit_out(flit_out),
        .last_src(last_src),
        .rx_count(rx_count),
        .seq_err_count(seq_err_count),
        .dest_err(dest_err),
        .valid_err(valid_err),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input int seq, input logic [1:0] src, input logic [3:0] dest);
        logic [8:0] s;
        s = seq[8:0];
        return {s, src, dest, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] f);
        write_in = 1'b1;
        data_in  = f;
        cycles(1);
        write_in = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        write_in = 1'b0;
        data_in  = 16'h0000;
        drain_en = 1'b1;
        full_seen = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_full", {15'd0, full}, 16'd0);
        check("rst_afull", {15'd0, almost_full}, 16'd0);
        check("rst_fvalid", {15'd0, flit_valid_out}, 16'd0);
        check("rst_rx", rx_count, 16'd0);
        check("rst_errs", {8'd0, seq_err_count}, 16'd0);
        check("rst_flags", {13'd0, dest_err, valid_err, overflow_err}, 16'd0);
        check("rst_flit", flit_out, 16'h0000);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        cycles(1);

        // Single flit: valid two edges after the strobe edge window
        send(16'h0017);
        check("t1_no_early", {15'd0, flit_valid_out}, 16'd0);
        cycles(1);
        check("t1_fvalid", {15'd0, flit_valid_out}, 16'd1);
        check("t1_flit", flit_out, 16'h0017);
        check("t1_rx", rx_count, 16'd1);
        check("t1_src", {14'd0, last_src}, 16'd0);
        cycles(1);
        check("t1_one_cycle", {15'd0, flit_valid_out}, 16'd0);
        check("t1_hold", flit_out, 16'h0017);
        check("t1_errs", {5'd0, seq_err_count, dest_err, valid_err, overflow_err}, 16'd0);

        // 20 back-to-back flits from src2
        write_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = mk(i, 2'd2, 4'b1011);
            cycles(1);
            full_seen = full_seen | full;
        end
        write_in = 1'b0;
        cycles(3);
        check("t2_rx", rx_count, 16'd21);
        check("t2_seqerr", {8'd0, seq_err_count}, 16'd0);
        check("t2_never_full", {15'd0, full_seen}, 16'd0);
        check("t2_src", {14'd0, last_src}, 16'd2);
        check("t2_flit", flit_out, mk(19, 2'd2, 4'b1011));

        // Fill to almost_full, full, then overflow
        drain_en = 1'b0;
        write_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in = mk(i, 2'd3, 4'b1011);
            cycles(1);
        end
        write_in = 1'b0;
        check("t3_afull7", {15'd0, almost_full}, 16'd1);
        check("t3_notfull7", {15'd0, full}, 16'd0);
        send(mk(7, 2'd3, 4'b1011));
        check("t3_full8", {15'd0, full}, 16'd1);
        check("t3_no_ovf_yet", {15'd0, overflow_err}, 16'd0);
        send(mk(8, 2'd3, 4'b1011));
        check("t3_ovf", {15'd0, overflow_err}, 16'd1);
        check("t3_still_full", {15'd0, full}, 16'd1);
        check("t3_no_drain", rx_count, 16'd21);
        drain_en = 1'b1;
        cycles(12);
        check("t3_rx", rx_count, 16'd29);
        check("t3_empty", {14'd0, full, almost_full}, 16'd0);
        check("t3_last", flit_out, mk(7, 2'd3, 4'b1011));
        check("t3_seqerr", {8'd0, seq_err_count}, 16'd0);

        // Src1 sequence gap 0,1,3,4 then 5
        send(mk(0, 2'd1, 4'b1011));
        send(mk(1, 2'd1, 4'b1011));
        send(mk(3, 2'd1, 4'b1011));
        send(mk(4, 2'd1, 4'b1011));
        cycles(3);
        check("t4_seqerr", {8'd0, seq_err_count}, 16'd1);
        check("t4_rx", rx_count, 16'd33);
        send(mk(5, 2'd1, 4'b1011));
        cycles(3);
        check("t4_resync", {8'd0, seq_err_count}, 16'd1);

        // Wrong destination, then an invalid strobe
        check("t5_dest_pre", {15'd0, dest_err}, 16'd0);
        send(mk(6, 2'd1, 4'b1010));
        cycles(3);
        check("t5_dest", {15'd0, dest_err}, 16'd1);
        check("t5_rx", rx_count, 16'd35);
        check("t5_seq_ok", {8'd0, seq_err_count}, 16'd1);
        check("t5_valid_pre", {15'd0, valid_err}, 16'd0);
        send(16'h0000);
        cycles(3);
        check("t5_valid", {15'd0, valid_err}, 16'd1);
        check("t5_rx_same", rx_count, 16'd35);

        // Async reset with 5 flits queued
        drain_en = 1'b0;
        write_in = 1'b1;
        for (int i = 1; i < 6; i++) begin
            data_in = mk(i, 2'd0, 4'b1011);
            cycles(1);
        end
        write_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_full", {15'd0, full}, 16'd0);
        check("t6_afull", {15'd0, almost_full}, 16'd0);
        check("t6_rx", rx_count, 16'd0);
        check("t6_fvalid", {15'd0, flit_valid_out}, 16'd0);
        check("t6_flags", {13'd0, dest_err, valid_err, overflow_err}, 16'd0);
        #2 reset = 1'b0;
        drain_en = 1'b1;
        cycles(1);
        cycles(3);
        check("t6_discarded", rx_count, 16'd0);
        send(mk(7, 2'd1, 4'b1011));
        send(mk(0, 2'd0, 4'b1011));
        cycles(3);
        check("t6_seq_reset", {8'd0, seq_err_count}, 16'd1);
        check("t6_rx2", rx_count, 16'd2);
        check("t6_last", flit_out, mk(0, 2'd0, 4'b1011));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
